pc_unit_btb: RTL and testbench

- Parametrised fetch-stage program counter for the pipelined RV32I core.
- Generates the fetch address each cycle and holds it on memory stalls.
- Accepts execute-stage redirects.
- Predicts taken control transfers with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters.
- Outputs the current and previous fetch addresses to the IF/ID pipeline register.

---
 rtl/pc_unit_btb.sv | 121 ++++++++++++
 tb/tb_pc_unit_btb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_btb.sv
// Fetch-stage program counter with a direct-mapped BTB of 2-bit saturating counters.
// Redirects beat stalls, stalls beat predictions, and predictions beat sequential fetch.
module pc_unit_btb #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
  parameter int               BTB_ENTRIES  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_prev,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    sat_inc = (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    sat_dec = (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [XLEN-1:0]        pc_r;
  logic [XLEN-1:0]        pc_prev_r;
  logic [XLEN-1:0]        pc_next_s;
  logic                   pc_load_s;

  logic [BTB_ENTRIES-1:0] valid_r;
  logic [1:0]             ctr_r    [BTB_ENTRIES];
  logic [TAGW-1:0]        tag_r    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_r [BTB_ENTRIES];

  logic [IDX-1:0]         lk_idx_s;
  logic [TAGW-1:0]        lk_tag_s;
  logic                   lk_hit_s;
  logic [IDX-1:0]         upd_idx_s;
  logic [TAGW-1:0]        upd_tag_s;
  logic                   upd_hit_s;
  logic                   unused_s;

  assign lk_idx_s  = pc_r[IDX+1:2];
  assign lk_tag_s  = pc_r[XLEN-1:IDX+2];
  assign lk_hit_s  = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);

  assign upd_idx_s = btb_upd_pc[IDX+1:2];
  assign upd_tag_s = btb_upd_pc[XLEN-1:IDX+2];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  // Byte-offset bits never take part in BTB indexing or tagging.
  assign unused_s  = ^{pc_r[1:0], btb_upd_pc[1:0]};

  assign pred_taken  = lk_hit_s && (ctr_r[lk_idx_s] >= 2'd2);
  assign pred_target = target_r[lk_idx_s];
  assign pc_out      = pc_r;
  assign pc_prev     = pc_prev_r;

  // Next fetch address selection.
  always_comb begin
    pc_next_s = pc_r + PC_STEP;
    pc_load_s = 1'b1;
    if (redirect_valid) begin
      pc_next_s = redirect_addr;
    end else if (stall) begin
      pc_next_s = pc_r;
      pc_load_s = 1'b0;
    end else if (pred_taken) begin
      pc_next_s = pred_target;
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // PC and previous-PC registers; pc_prev only moves when pc_out does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= RESET_VECTOR;
      pc_prev_r <= RESET_VECTOR;
    end else if (pc_load_s) begin
      pc_r      <= pc_next_s;
      pc_prev_r <= pc_r;
    end
  end

  // BTB valid bits and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {BTB_ENTRIES{1'b0}};
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_r[i] <= 2'd0;
      end
    end else if (btb_upd_valid) begin
      if (btb_upd_taken) begin
        valid_r[upd_idx_s] <= 1'b1;
        ctr_r[upd_idx_s]   <= upd_hit_s ? sat_inc(ctr_r[upd_idx_s]) : 2'd2;
      end else if (upd_hit_s) begin
        ctr_r[upd_idx_s]   <= sat_dec(ctr_r[upd_idx_s]);
      end
    end
  end

  // BTB tags and targets; gated by valid so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_upd_valid && btb_upd_taken) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= btb_upd_target;
    end
  end

endmodule

// File: tb/tb_pc_unit_btb.sv
// Scoreboard bench for pc_unit_btb: a reference model pushes expected state per cycle,
// the post-edge sampler pops and compares. Two extra instances cover PC wrap-around.
module tb_pc_unit_btb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect_valid, btb_upd_valid, btb_upd_taken;
  logic [31:0] redirect_addr, btb_upd_pc, btb_upd_target;
  logic [31:0] pc_out, pc_prev, pred_target;
  logic        pred_taken;

  logic        z1  = 1'b0;
  logic [31:0] z32 = 32'd0;
  logic [15:0] z16 = 16'd0;
  logic [31:0] w32_pc, w32_prev, w32_tgt;
  logic        w32_pt;
  logic [15:0] w16_pc, w16_prev, w16_tgt;
  logic        w16_pt;

  pc_unit_btb dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .pc_out(pc_out), .pc_prev(pc_prev),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  pc_unit_btb #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC)) dut_w32 (
    .clk(clk), .rst(rst), .stall(z1),
    .redirect_valid(z1), .redirect_addr(z32),
    .btb_upd_valid(z1), .btb_upd_pc(z32),
    .btb_upd_target(z32), .btb_upd_taken(z1),
    .pc_out(w32_pc), .pc_prev(w32_prev),
    .pred_taken(w32_pt), .pred_target(w32_tgt)
  );

  pc_unit_btb #(.XLEN(16), .RESET_VECTOR(16'hFFFC)) dut_w16 (
    .clk(clk), .rst(rst), .stall(z1),
    .redirect_valid(z1), .redirect_addr(z16),
    .btb_upd_valid(z1), .btb_upd_pc(z16),
    .btb_upd_target(z16), .btb_upd_taken(z1),
    .pc_out(w16_pc), .pc_prev(w16_prev),
    .pred_taken(w16_pt), .pred_target(w16_tgt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] prev;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 8 entries, index addr[4:2], tag addr[31:5].
  logic [31:0] m_pc, m_prev;
  logic        m_valid [8];
  logic [26:0] m_tag   [8];
  logic [31:0] m_tgt   [8];
  int          m_ctr   [8];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic m_pred(input logic [31:0] a);
    m_pred = m_valid[a[4:2]] && (m_tag[a[4:2]] == a[31:5]) && (m_ctr[a[4:2]] >= 2);
  endfunction

  task automatic model_reset();
    m_pc   = 32'd0;
    m_prev = 32'd0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] ra,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                      input logic ut);
    exp_t        e;
    logic [31:0] npc;
    logic [2:0]  j;
    logic        h;
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_addr = ra;
    btb_upd_valid = uv; btb_upd_pc = upc; btb_upd_target = utg; btb_upd_taken = ut;
    if (rv)                npc = ra;
    else if (st)           npc = m_pc;
    else if (m_pred(m_pc)) npc = m_tgt[m_pc[4:2]];
    else                   npc = m_pc + 32'd4;
    if (rv || !st) m_prev = m_pc;
    m_pc = npc;
    if (uv) begin
      j = upc[4:2];
      h = m_valid[j] && (m_tag[j] == upc[31:5]);
      if (ut) begin
        if (h) begin
          m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
        end else begin
          m_valid[j] = 1'b1;
          m_tag[j]   = upc[31:5];
          m_ctr[j]   = 2;
        end
        m_tgt[j] = utg;
      end else if (h) begin
        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
      end
    end
    e.pc = m_pc; e.prev = m_prev; e.pt = m_pred(m_pc); e.tgt = m_tgt[m_pc[4:2]];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("pc_out", pc_out, e.pc);
    check_eq("pc_prev", pc_prev, e.prev);
    check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
    if (e.pt) check_eq("pred_target", pred_target, e.tgt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic redir(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    step(1'b0, 1'b0, 32'd0, 1'b1, p, t, tk);
  endtask

  // Called just after a sampled edge: reset must take effect before the next edge.
  task automatic mid_reset();
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst_pc", pc_out, 32'd0);
    check_eq("async_rst_prev", pc_prev, 32'd0);
    check_eq("async_rst_pred", {31'd0, pred_taken}, 32'd0);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'd0;
    btb_upd_valid = 1'b0; btb_upd_pc = 32'd0; btb_upd_target = 32'd0; btb_upd_taken = 1'b0;
    model_reset();
    #12;
    check_eq("rst_pc", pc_out, 32'd0);
    check_eq("rst_prev", pc_prev, 32'd0);
    check_eq("rst_pred", {31'd0, pred_taken}, 32'd0);
    check_eq("rst_w32", w32_pc, 32'hFFFF_FFFC);
    check_eq("rst_w16", {16'd0, w16_pc}, 32'h0000_FFFC);
    @(posedge clk);
    #2 rst = 1'b1;

    // Sequential fetch and wrap-around
    idle();
    check_eq("wrap_w32", w32_pc, 32'd0);
    check_eq("wrap_w16", {16'd0, w16_pc}, 32'd0);
    check_eq("wrap_w32_prev", w32_prev, 32'hFFFF_FFFC);
    for (int i = 0; i < 7; i++) idle();
    mid_reset();

    // Stall hold, then redirect overriding a stall
    for (int i = 0; i < 4; i++) idle();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 1'b0);

    // Allocate on the same edge as a redirect, then predict 0x8 -> 0x40
    step(1'b0, 1'b1, 32'h0, 1'b1, 32'h8, 32'h40, 1'b1);
    idle(); idle(); idle();

    // Aliasing at index 2
    redir(32'h28);
    idle();
    upd(32'h28, 32'h80, 1'b1);
    redir(32'h8);
    redir(32'h28);
    idle();

    // Hysteresis and saturation
    upd(32'h8, 32'h40, 1'b1);
    upd(32'h8, 32'h40, 1'b0);
    redir(32'h8);
    idle();
    for (int i = 0; i < 3; i++) upd(32'h8, 32'h40, 1'b1);
    upd(32'h8, 32'h40, 1'b0);
    redir(32'h8);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h8, 32'h40, 1'b0);
    redir(32'h8);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h8, 32'h40, 1'b1);
    redir(32'h8);

    // Reset while an entry predicts taken clears the BTB
    mid_reset();
    idle(); idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
